mem_arbiter2: RTL and testbench

Two-master, one-slave arbiter for the native memory bus (valid/ready/addr/wdata/wstrb/rdata) in front of the peripheral region (GPIO and siblings). It lets the CPU and a second requester (debug or DMA port) share one peripheral port. Requests are granted round-robin, and the grant is held until the slave completes the transaction. A timeout completes hung transactions with an error word, so neither master can stall the bus forever.

---
 rtl/bus_pkg.sv | 19 +
 rtl/mem_arbiter2_if.sv | 19 +
 rtl/bus_timeout.sv | 41 ++++
 rtl/mem_arbiter2.sv | 104 ++++++++++
 tb/tb_mem_arbiter2.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the native memory bus (valid/ready/addr/
// wdata/wstrb/rdata) and the arbiters sitting on it.
//   BUS_AW/BUS_DW/BUS_SW : address, data and strobe widths
//   ERR_DATA_DEF         : read word returned when a transaction times out
//   arb_state_e          : arbiter state encoding
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_SW = 4;

  localparam logic [BUS_DW-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter2_if.sv
// mem_arbiter2_if: one native memory bus link.
//   valid/addr/wdata/wstrb : request, driven by the requester (wstrb==0 is a read)
//   ready/rdata            : response, driven by the responder
// modport master : the side that issues requests
// modport slave  : the side that answers them
interface mem_arbiter2_if;
  import bus_pkg::*;

  logic              valid;
  logic [BUS_AW-1:0] addr;
  logic [BUS_DW-1:0] wdata;
  logic [BUS_SW-1:0] wstrb;
  logic              ready;
  logic [BUS_DW-1:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/bus_timeout.sv
// bus_timeout: stall counter for a granted bus transaction.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : hold the counter at zero (asserted while no grant is active)
//   en_i       : count this cycle (granted request outstanding, no ready)
//   expire_o   : high in the TIMEOUT-th counted cycle; combinational from en_i
// TIMEOUT==0 removes the counter and ties expire_o low.
module bus_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  if (TIMEOUT == 0) begin : g_off
    assign expire_o = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturate at TIMEOUT so a long stall can never wrap back into range.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                                cnt_d = '0;
      else if (en_i && (cnt_q != CW'(TIMEOUT))) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    // cnt_q holds the number of stalled cycles already seen, so the
    // TIMEOUT-th stalled cycle is the one where it reads TIMEOUT-1.
    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-master, one-slave round-robin arbiter for the peripheral
// region. The grant is held until the slave completes; a hung slave is cut
// off after TIMEOUT stalled cycles with ERR_DATA and a timeout_err pulse.
//   clk, rst_n  : clock, synchronous active-low reset
//   m0 (slave)  : master 0 (CPU) link
//   m1 (slave)  : master 1 (debug/DMA) link
//   s  (master) : link to the peripheral slave
//   timeout_err : one-cycle pulse on a forced completion
module mem_arbiter2
  import bus_pkg::*;
#(
  parameter int                TIMEOUT  = 16,
  parameter logic [BUS_DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter2_if.slave  m0,
  mem_arbiter2_if.slave  m1,
  mem_arbiter2_if.master s,
  output logic           timeout_err
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;   // 0 = m0, 1 = m1
  logic       last_q,  last_d;    // master served by the last completion

  logic busy;
  logic gnt_valid;
  logic expire;

  assign busy      = (state_q == ARB_BUSY);
  assign gnt_valid = busy && (grant_q ? m1.valid : m0.valid);

  // Only a live, stalled request ages; a valid drop ends BUSY on its own.
  bus_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!busy),
    .en_i     (gnt_valid && !s.ready),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;    // m0 wins the first tie
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    s.valid     = 1'b0;
    s.addr      = '0;
    s.wdata     = '0;
    s.wstrb     = '0;
    m0.ready    = 1'b0;
    m1.ready    = 1'b0;
    m0.rdata    = s.rdata;
    m1.rdata    = s.rdata;
    timeout_err = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // s.ready is deliberately ignored here: it may be a late response
        // to a transaction that already timed out.
        if (m0.valid || m1.valid) begin
          state_d = ARB_BUSY;
          grant_d = (m0.valid && m1.valid) ? ~last_q : m1.valid;
        end
      end
      ARB_BUSY: begin
        if (!gnt_valid) begin
          // Protocol abort: release without a ready and keep the history.
          state_d = ARB_IDLE;
        end else begin
          s.valid = !expire;
          s.addr  = grant_q ? m1.addr  : m0.addr;
          s.wdata = grant_q ? m1.wdata : m0.wdata;
          s.wstrb = grant_q ? m1.wstrb : m0.wstrb;
          // expire already excludes s.ready, so a real response wins the race.
          if (s.ready || expire) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
            if (grant_q) m1.ready = 1'b1;
            else         m0.ready = 1'b1;
          end
          if (expire) begin
            timeout_err = 1'b1;
            if (grant_q) m1.rdata = ERR_DATA;
            else         m0.rdata = ERR_DATA;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: directed scenarios followed by a randomized run, every
// cycle compared against a transaction-level reference model of the arbiter.
module tb_mem_arbiter2;
  import bus_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeout_err;

  mem_arbiter2_if m0if ();
  mem_arbiter2_if m1if ();
  mem_arbiter2_if sif ();

  mem_arbiter2 #(.TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0if),
    .m1          (m1if),
    .s           (sif),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: who owns the bus, for how many stalled cycles, and who
  // was served by the last completed transaction.
  bit mown;
  int mg, ml, mage;

  logic exp_r0, exp_r1;
  int          ev_m[$];
  int          ev_c[$];
  logic [31:0] ev_d[$];
  int n_to, to_cyc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int evm(int i);
    return (i < ev_m.size()) ? ev_m[i] : -1;
  endfunction
  function automatic int evc(int i);
    return (i < ev_c.size()) ? ev_c[i] : -1;
  endfunction
  function automatic logic [31:0] evd(int i);
    return (i < ev_d.size()) ? ev_d[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clr_ev();
    ev_m.delete(); ev_c.delete(); ev_d.delete();
    n_to = 0; to_cyc = -1;
  endtask

  task automatic set_m(int m, logic v, logic [31:0] a, logic [31:0] d, logic [3:0] st);
    if (m == 0) begin
      m0if.valid = v; m0if.addr = a; m0if.wdata = d; m0if.wstrb = st;
    end else begin
      m1if.valid = v; m1if.addr = a; m1if.wdata = d; m1if.wstrb = st;
    end
  endtask

  task automatic new_req(int m);
    set_m(m, 1'b1, 32'h0300_0000 | ($urandom & 32'h0000_FFFC), $urandom,
          4'($urandom_range(0, 15)));
  endtask

  // One clock: inputs are already applied; check outputs mid-cycle, then
  // advance the model with the values seen at the edge.
  task automatic tick();
    logic sr, m0v, m1v, gv, pay;
    logic [31:0] sd;
    logic e_sv, e_r0, e_r1, e_to;
    logic [31:0] e_sa, e_sw, e_d0, e_d1;
    logic [3:0] e_ss;
    #2;
    sr = sif.ready; sd = sif.rdata; m0v = m0if.valid; m1v = m1if.valid;
    e_sv = 0; e_sa = 0; e_sw = 0; e_ss = 0;
    e_r0 = 0; e_r1 = 0; e_to = 0; e_d0 = sd; e_d1 = sd;
    pay = 1; gv = 0;
    if (mown) begin
      gv  = (mg == 1) ? m1v : m0v;
      pay = 0;
      if (gv) begin
        if (sr || (mage != TMO - 1)) begin
          e_sv = 1; pay = 1;
          e_sa = (mg == 1) ? m1if.addr  : m0if.addr;
          e_sw = (mg == 1) ? m1if.wdata : m0if.wdata;
          e_ss = (mg == 1) ? m1if.wstrb : m0if.wstrb;
        end
        if (sr || (mage == TMO - 1)) begin
          if (mg == 1) e_r1 = 1; else e_r0 = 1;
        end
        if (!sr && (mage == TMO - 1)) begin
          e_to = 1;
          if (mg == 1) e_d1 = 32'hDEAD_BEEF; else e_d0 = 32'hDEAD_BEEF;
        end
      end
    end
    chk("s_valid", sif.valid, e_sv);
    if (pay) begin
      chk("s_addr",  sif.addr,  e_sa);
      chk("s_wdata", sif.wdata, e_sw);
      chk("s_wstrb", sif.wstrb, e_ss);
    end
    chk("m0_ready", m0if.ready, e_r0);
    chk("m1_ready", m1if.ready, e_r1);
    chk("timeout_err", timeout_err, e_to);
    chk("m0_rdata", m0if.rdata, e_d0);
    chk("m1_rdata", m1if.rdata, e_d1);
    exp_r0 = e_r0; exp_r1 = e_r1;
    if (m0if.ready === 1'b1) begin ev_m.push_back(0); ev_c.push_back(cyc); ev_d.push_back(m0if.rdata); end
    if (m1if.ready === 1'b1) begin ev_m.push_back(1); ev_c.push_back(cyc); ev_d.push_back(m1if.rdata); end
    if (timeout_err === 1'b1) begin n_to++; to_cyc = cyc; end
    @(posedge clk);
    if (!rst_n) begin
      mown = 0; mg = 0; ml = 1; mage = 0;
    end else if (mown) begin
      if (!gv) mown = 0;
      else if (sr || (mage == TMO - 1)) begin mown = 0; ml = mg; end
      else mage++;
    end else if (m0v || m1v) begin
      mown = 1; mage = 0;
      mg = (m0v && m1v) ? 1 - ml : (m1v ? 1 : 0);
    end
    cyc++;
    #1;
  endtask

  // Tick, then let each master react to its ready: new request or release.
  task automatic tick_auto(bit keep0, bit keep1);
    tick();
    if (exp_r0) begin if (keep0) new_req(0); else m0if.valid = 1'b0; end
    if (exp_r1) begin if (keep1) new_req(1); else m1if.valid = 1'b0; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, cnt0, cnt1;
    bit dead;
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    sif.ready = 0; sif.rdata = 32'h0;
    mown = 0; mg = 0; ml = 1; mage = 0;
    clr_ev();
    @(posedge clk); #1;
    tick();                       // reset held: all outputs quiet
    rst_n = 1;
    tick();

    // Tie after reset: m0, m1, m0, m1, completions 2 cycles apart.
    clr_ev();
    sif.ready = 1; sif.rdata = 32'h5555_AAAA;
    new_req(0); new_req(1);
    repeat (8) tick_auto(1, 1);
    m0if.valid = 0; m1if.valid = 0; sif.ready = 0;
    repeat (2) tick();
    chk("tie_count", ev_m.size(), 4);
    for (int i = 0; i < 4; i++) chk("tie_order", evm(i), i % 2);
    for (int i = 1; i < 4; i++) chk("tie_gap", evc(i) - evc(i - 1), 2);

    // Single write, slave ready one cycle after s_valid.
    clr_ev();
    set_m(0, 1, 32'h0300_0000, 32'h0000_00AB, 4'hF);
    c0 = cyc;
    tick_auto(0, 0);
    tick_auto(0, 0);
    sif.ready = 1; sif.rdata = $urandom;
    tick_auto(0, 0);
    sif.ready = 0;
    repeat (2) tick();
    cnt0 = 0; cnt1 = 0;
    foreach (ev_m[i]) if (ev_m[i] == 0) cnt0++; else cnt1++;
    chk("wr_m0_ready_pulses", cnt0, 1);
    chk("wr_m1_ready_pulses", cnt1, 0);
    chk("wr_latency", evc(0) - c0, 2);

    // Fairness: m0 slips in between two m1 transactions.
    clr_ev();
    new_req(1);
    tick_auto(0, 1);
    tick_auto(0, 1);
    new_req(0); sif.ready = 1;
    repeat (5) tick_auto(0, 1);
    m1if.valid = 0; sif.ready = 0;
    repeat (2) tick();
    chk("fair_count", ev_m.size(), 3);
    chk("fair_0", evm(0), 1);
    chk("fair_1", evm(1), 0);
    chk("fair_2", evm(2), 1);

    // Timeout on an m1 read, then a stray slave ready in IDLE.
    clr_ev();
    set_m(1, 1, 32'h0300_0010, 32'h0, 4'h0);
    c0 = cyc;
    repeat (17) tick_auto(0, 0);
    chk("to_count", ev_m.size(), 1);
    chk("to_master", evm(0), 1);
    chk("to_cycle", evc(0) - c0, 16);
    chk("to_rdata", evd(0), 32'hDEAD_BEEF);
    chk("to_pulses", n_to, 1);
    chk("to_err_cycle", to_cyc - c0, 16);
    sif.ready = 1; sif.rdata = 32'hCAFE_F00D;
    repeat (3) tick();
    sif.ready = 0;
    chk("stray_ready", ev_m.size(), 1);

    // Race: slave answers on the very cycle the timeout would fire.
    clr_ev();
    set_m(0, 1, 32'h0300_0020, 32'h0, 4'h0);
    c0 = cyc;
    repeat (16) tick_auto(0, 0);
    sif.ready = 1; sif.rdata = 32'h1234_5678;
    tick_auto(0, 0);
    sif.ready = 0;
    tick();
    chk("race_master", evm(0), 0);
    chk("race_cycle", evc(0) - c0, 16);
    chk("race_rdata", evd(0), 32'h1234_5678);
    chk("race_no_err", n_to, 0);

    // Reset in the middle of an m1 transaction.
    clr_ev();
    new_req(1);
    tick_auto(0, 0);
    tick_auto(0, 0);
    rst_n = 0;
    tick_auto(0, 0);
    rst_n = 1;
    chk("rst_no_ready", ev_m.size(), 0);
    new_req(0); sif.ready = 1;
    repeat (4) tick_auto(0, 0);
    sif.ready = 0;
    chk("rst_tie_0", evm(0), 0);
    chk("rst_tie_1", evm(1), 1);

    // Randomized traffic: slave stalls, dead slave phases, aborts, resets.
    dead = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) dead = ($urandom_range(0, 2) == 0);
      sif.ready = dead ? 1'b0 : ($urandom_range(0, 2) == 0);
      sif.rdata = $urandom;
      if (!m0if.valid) begin if ($urandom_range(0, 3) == 0) new_req(0); end
      else if ($urandom_range(0, 63) == 0) m0if.valid = 0;
      if (!m1if.valid) begin if ($urandom_range(0, 3) == 0) new_req(1); end
      else if ($urandom_range(0, 63) == 0) m1if.valid = 0;
      rst_n = ($urandom_range(0, 499) != 0);
      tick_auto(0, 0);
    end
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
